// File: rtl/npc_resolve_pkg.sv
// Shared types and constants for the branch/jump resolution unit.
package npc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BR   = 3'd1,
        OP_JAL  = 3'd2,
        OP_JALR = 3'd3
    } op_e;

    localparam int AW_DEF       = 27;
    localparam int RESET_PC_DEF = 16280;
    localparam int SHADOW_DEF   = 2;
    localparam int CW_DEF       = 32;

    function automatic logic [63:0] align4(input logic [63:0] a);
        return a & ~64'h3;
    endfunction

endpackage

// File: rtl/npc_resolve_if.sv
// Execute-stage inputs and fetch-redirect outputs of npc_resolve.
interface npc_resolve_if #(
    parameter int AW = npc_pkg::AW_DEF,
    parameter int CW = npc_pkg::CW_DEF
);
    logic          n_stall;
    logic          ex_valid;
    logic [2:0]    ex_op;
    logic          ex_taken;
    logic [AW-1:0] ex_pc;
    logic [AW-1:0] ex_imm;
    logic [AW-1:0] ex_rs1;
    logic [AW-1:0] npc;
    logic          npc_enn;
    logic          ex_kill;
    logic [AW-1:0] ex_link;
    logic [CW-1:0] redirect_cnt;

    // master is the redirect producer (npc_resolve itself)
    modport master (
        input  n_stall, ex_valid, ex_op, ex_taken, ex_pc, ex_imm, ex_rs1,
        output npc, npc_enn, ex_kill, ex_link, redirect_cnt
    );

    modport slave (
        output n_stall, ex_valid, ex_op, ex_taken, ex_pc, ex_imm, ex_rs1,
        input  npc, npc_enn, ex_kill, ex_link, redirect_cnt
    );
endinterface

// File: rtl/npc_resolve.sv
// Resolves branch/jump targets from ex, issues PC redirects and kills the
// wrong-path shadow that follows each redirect.
module npc_resolve
    import npc_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
    parameter int            SHADOW   = SHADOW_DEF,
    parameter int            CW       = CW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    npc_resolve_if.master bus
);

    localparam int SW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

    logic [AW-1:0] r_npc;
    logic          r_npc_enn;
    logic [SW-1:0] r_shadow;
    logic [CW-1:0] r_redirect_cnt;

    logic          w_kill;
    logic          w_live;
    logic          w_redirect;
    logic [AW-1:0] w_br_target;
    logic [AW-1:0] w_jalr_sum;
    logic [AW-1:0] w_target;

    assign w_kill      = bus.ex_valid && (r_shadow != '0);
    assign w_live      = bus.n_stall && bus.ex_valid && !w_kill;
    assign w_br_target = bus.ex_pc + bus.ex_imm;
    assign w_jalr_sum  = bus.ex_rs1 + bus.ex_imm;

    // Undefined op codes fall into the default arm and behave as OP_NONE.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_br_target;
        case (bus.ex_op)
            OP_BR:   w_redirect = w_live && bus.ex_taken;
            OP_JAL:  w_redirect = w_live;
            OP_JALR: begin
                w_redirect = w_live;
                w_target   = AW'(align4(64'(w_jalr_sum)));
            end
            default: w_redirect = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_npc          <= RESET_PC;
            r_npc_enn      <= 1'b0;
            r_shadow       <= '0;
            r_redirect_cnt <= '0;
        end else if (w_redirect) begin
            r_npc          <= w_target;
            r_npc_enn      <= 1'b1;
            r_shadow       <= SW'(SHADOW);
            r_redirect_cnt <= r_redirect_cnt + 1'b1;
        end else begin
            if (bus.n_stall)
                r_npc_enn <= 1'b0;
            if (bus.n_stall && w_kill)
                r_shadow <= r_shadow - 1'b1;
        end
    end

    assign bus.npc          = r_npc;
    assign bus.npc_enn      = r_npc_enn;
    assign bus.ex_kill      = w_kill;
    assign bus.ex_link      = bus.ex_pc + AW'(4);
    assign bus.redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_npc_resolve.sv
// Directed-vector bench for npc_resolve with hand-computed expectations.
module tb_npc_resolve;
    import npc_pkg::*;

    localparam int AW = 27;
    localparam int CW = 32;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    npc_resolve_if #(.AW(AW), .CW(CW)) bus ();

    npc_resolve #(.AW(AW), .RESET_PC(27'd16280), .SHADOW(2), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic tk,
                         input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                         input logic [AW-1:0] rs1);
        bus.ex_valid = v;
        bus.ex_op    = op;
        bus.ex_taken = tk;
        bus.ex_pc    = pc;
        bus.ex_imm   = imm;
        bus.ex_rs1   = rs1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus.n_stall = 1'b1;
        drive(1'b0, OP_NONE, 1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_npc",  64'(bus.npc), 64'd16280);
        chk("rst_enn",  64'(bus.npc_enn), 64'd0);
        chk("rst_cnt",  64'(bus.redirect_cnt), 64'd0);
        chk("rst_kill", 64'(bus.ex_kill), 64'd0);

        drive(1'b0, OP_NONE, 1'b0, 27'd100, '0, '0);
        #1 chk("link", 64'(bus.ex_link), 64'd104);
        drive(1'b0, OP_NONE, 1'b0, 27'h7FFFFFC, '0, '0);
        #1 chk("link_wrap", 64'(bus.ex_link), 64'd0);

        // JAL 100 + (-8)
        drive(1'b1, OP_JAL, 1'b0, 27'd100, 27'h7FFFFF8, '0);
        #1 chk("jal_kill_pre", 64'(bus.ex_kill), 64'd0);
        step();
        chk("jal_npc", 64'(bus.npc), 64'd92);
        chk("jal_enn", 64'(bus.npc_enn), 64'd1);
        chk("jal_cnt", 64'(bus.redirect_cnt), 64'd1);

        drive(1'b1, OP_NONE, 1'b0, 27'd104, '0, '0);
        #1 chk("shadow1_kill", 64'(bus.ex_kill), 64'd1);
        step();
        chk("consume_enn", 64'(bus.npc_enn), 64'd0);

        // taken branch while killed: must not redirect
        drive(1'b1, OP_BR, 1'b1, 27'd200, 27'd40, '0);
        #1 chk("shadow2_kill", 64'(bus.ex_kill), 64'd1);
        step();
        chk("killed_br_enn", 64'(bus.npc_enn), 64'd0);
        chk("killed_br_cnt", 64'(bus.redirect_cnt), 64'd1);
        chk("killed_br_npc", 64'(bus.npc), 64'd92);
        drive(1'b1, OP_NONE, 1'b0, 27'd204, '0, '0);
        #1 chk("shadow3_kill", 64'(bus.ex_kill), 64'd0);
        step();

        // JALR wraps then aligns
        drive(1'b1, OP_JALR, 1'b0, 27'd300, 27'd7, 27'h7FFFFFE);
        step();
        chk("jalr_npc", 64'(bus.npc), 64'd4);
        chk("jalr_enn", 64'(bus.npc_enn), 64'd1);
        chk("jalr_cnt", 64'(bus.redirect_cnt), 64'd2);

        // stall holds everything, shadow untouched
        bus.n_stall = 1'b0;
        drive(1'b1, OP_JAL, 1'b0, 27'd400, 27'd64, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_npc",  64'(bus.npc), 64'd4);
            chk("stall_enn",  64'(bus.npc_enn), 64'd1);
            chk("stall_kill", 64'(bus.ex_kill), 64'd1);
            chk("stall_cnt",  64'(bus.redirect_cnt), 64'd2);
        end

        // bubble consumes the redirect but not the shadow
        bus.n_stall = 1'b1;
        drive(1'b0, OP_NONE, 1'b0, '0, '0, '0);
        step();
        chk("unstall_enn", 64'(bus.npc_enn), 64'd0);
        drive(1'b1, OP_NONE, 1'b0, 27'd8, '0, '0);
        #1 chk("bubble_kill", 64'(bus.ex_kill), 64'd1);
        step();
        chk("post_bubble_kill", 64'(bus.ex_kill), 64'd1);
        step();
        chk("shadow_done", 64'(bus.ex_kill), 64'd0);

        // branch not taken
        drive(1'b1, OP_BR, 1'b0, 27'd300, 27'd16, '0);
        step();
        chk("nt_enn",  64'(bus.npc_enn), 64'd0);
        chk("nt_kill", 64'(bus.ex_kill), 64'd0);
        chk("nt_cnt",  64'(bus.redirect_cnt), 64'd2);

        // illegal op behaves as none
        drive(1'b1, 3'd6, 1'b1, 27'd300, 27'd16, 27'd80);
        step();
        chk("illegal_enn", 64'(bus.npc_enn), 64'd0);

        // branch taken
        drive(1'b1, OP_BR, 1'b1, 27'd300, 27'd16, '0);
        step();
        chk("bt_npc", 64'(bus.npc), 64'd316);
        chk("bt_enn", 64'(bus.npc_enn), 64'd1);
        chk("bt_cnt", 64'(bus.redirect_cnt), 64'd3);

        // reset on the consume edge
        rst = 1'b1;
        drive(1'b1, OP_JAL, 1'b0, 27'd500, 27'd8, '0);
        step();
        rst = 1'b0;
        drive(1'b1, OP_NONE, 1'b0, 27'd16280, '0, '0);
        #1;
        chk("rst2_npc",  64'(bus.npc), 64'd16280);
        chk("rst2_enn",  64'(bus.npc_enn), 64'd0);
        chk("rst2_kill", 64'(bus.ex_kill), 64'd0);
        chk("rst2_cnt",  64'(bus.redirect_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/npc_resolve.md
Name: npc_resolve

Overview:
- Branch/jump resolution unit. It is the producer side of the fetch-redirect interface.
- Takes the resolved control-flow instruction from the execute stage and computes its target.
- Drives npc/npc_enn into the PC register. The PC register loads npc when n_stall=1 and npc_enn=1; otherwise it advances by 4.
- Tracks the wrong-path shadow after each redirect and kills wrong-path instructions. Also keeps a redirect counter for performance measurement.

Parameters:
- AW, 27, address width; byte addresses, instructions 4-byte aligned.
- RESET_PC, 16280, value of npc after reset; must equal the PC register reset value.
- SHADOW, 2, number of accepted ex instructions killed after a redirect (pipeline depth fetch→ex minus 1).
- CW, 32, width of the redirect performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- n_stall  in  1  pipeline advance; ex inputs are sampled only when 1
- ex_valid  in  1  an instruction occupies ex
- ex_op  in  3  op_e (see package): OP_NONE, OP_BR, OP_JAL, OP_JALR
- ex_taken  in  1  branch condition result; meaningful only for OP_BR
- ex_pc  in  AW  address of the ex instruction
- ex_imm  in  AW  sign-extended offset, already truncated to AW
- ex_rs1  in  AW  rs1 operand, low AW bits
- npc  out  AW  redirect target to the PC register
- npc_enn  out  1  redirect pending
- ex_kill  out  1  ex instruction is wrong-path; suppress its writeback and side effects
- ex_link  out  AW  ex_pc+4, the link value for JAL/JALR
- redirect_cnt  out  CW  number of redirects issued, wrapping

Behaviour:
- Reset values:
  - npc=RESET_PC, npc_enn=0, shadow counter=0, ex_kill=0, redirect_cnt=0.
  - rst overrides everything in the same edge, including a pending redirect.
- "Accept" means an edge with n_stall=1. "Live" means accept && ex_valid && !ex_kill.
- ex_kill is combinational: ex_valid && (shadow_cnt != 0).
- ex_link is combinational: ex_pc+4, mod 2^AW.
- Target arithmetic is mod 2^AW; wrap-around is silent.
  - OP_BR taken, OP_JAL: ex_pc+ex_imm.
  - OP_JALR: (ex_rs1+ex_imm) with bits[1:0] forced to 0.
- Redirect condition: live && (OP_JAL || OP_JALR || (OP_BR && ex_taken)).
  - OP_BR not taken and OP_NONE never redirect.
- Latency: on a redirect-condition edge, npc←target and npc_enn←1, visible the next cycle (1-cycle latency). The same edge sets shadow_cnt←SHADOW and increments redirect_cnt.
- Hold: while npc_enn=1 and n_stall=0, npc and npc_enn stay unchanged.
- Consume: on an accept edge with npc_enn=1, the PC register takes npc. npc_enn←0 unless a new redirect condition occurs on that same edge; if so, the new target loads and npc_enn stays 1.
- When npc_enn=0, npc keeps its last value; it is don't-care to the consumer.
- Shadow:
  - On an accept edge with ex_valid=1 and shadow_cnt>0, shadow_cnt decrements.
  - Bubbles (ex_valid=0) and stalls do not decrement.
  - Killed instructions never redirect and never count.
- Reset mid-shadow or while a redirect is pending: everything clears and fetch restarts from RESET_PC through the PC register's own reset.
- Illegal ex_op codes are treated as OP_NONE.

Decomposition:
- Package npc_pkg:
  - op_e enum (3 bits).
  - Constants AW_DEF=27, RESET_PC_DEF=16280, SHADOW_DEF=2.
  - Function for target alignment (clear bits[1:0]).
- No sub-module is needed. The target adder is inline. The shadow counter is clog2(SHADOW+1) bits.

Test Plan:
- Reset, then idle with n_stall=1 and ex_valid=0 → npc=16280, npc_enn=0, redirect_cnt=0, ex_kill=0.
- OP_JAL with ex_pc=100 and ex_imm=-8 (27-bit) → next cycle npc=92, npc_enn=1. Then the next 2 ex_valid accepts show ex_kill=1, the 3rd shows ex_kill=0. redirect_cnt=1.
- OP_JALR with rs1=0x7FFFFFE and imm=7 → npc=0x0000004 (wraps, then bits[1:0] cleared). OP_BR with ex_taken=0 → npc_enn stays 0 and no shadow.
- Redirect, then n_stall=0 for 3 cycles → npc and npc_enn held; shadow_cnt unchanged even with ex_valid=1. First cycle with n_stall=1 → npc_enn falls after that edge.
- A taken OP_BR presented while ex_kill=1 → no redirect, redirect_cnt unchanged.
- A redirect pending with rst asserted on the consume edge → npc=16280, npc_enn=0, ex_kill=0 next cycle.
